// File: rtl/tt_sweep_checker.sv
// Exhaustive truth-table sweeper/checker for a single-output combinational DUT.
// Steps vec through 0..2^N_IN-1, holds each SETTLE cycles, and compares dut_f against EXP_TABLE.
module tt_sweep_checker #(
  parameter int unsigned              N_IN      = 4,
  parameter logic [(2**N_IN)-1:0]     EXP_TABLE = '0,
  parameter int unsigned              SETTLE    = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            stop_on_fail,
  input  logic            dut_f,
  output logic [N_IN-1:0] vec,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic            fail_valid,
  output logic [N_IN-1:0] first_fail
);

  localparam int unsigned CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);
  localparam logic [N_IN-1:0]  VEC_LAST = '1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t            r_state, w_state_nxt;
  logic [N_IN-1:0]   r_vec, w_vec_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_done, w_done_nxt;
  logic              r_pass, w_pass_nxt;
  logic [N_IN:0]     r_err, w_err_nxt;
  logic              r_fail_valid, w_fail_valid_nxt;
  logic [N_IN-1:0]   r_first_fail, w_first_fail_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic              r_stop, w_stop_nxt;
  logic              w_mismatch;

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt      = r_state;
    w_vec_nxt        = r_vec;
    w_busy_nxt       = r_busy;
    w_done_nxt       = r_done;
    w_pass_nxt       = r_pass;
    w_err_nxt        = r_err;
    w_fail_valid_nxt = r_fail_valid;
    w_first_fail_nxt = r_first_fail;
    w_cnt_nxt        = r_cnt;
    w_stop_nxt       = r_stop;
    w_mismatch       = 1'b0;

    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_state_nxt      = S_RUN;
          w_busy_nxt       = 1'b1;
          w_done_nxt       = 1'b0;
          w_pass_nxt       = 1'b0;
          w_vec_nxt        = '0;
          w_err_nxt        = '0;
          w_fail_valid_nxt = 1'b0;
          w_first_fail_nxt = '0;
          w_cnt_nxt        = '0;
          w_stop_nxt       = stop_on_fail;
        end
      end
      S_RUN: begin
        if (r_cnt == CNT_LAST) begin
          // Sample edge: the vector has been held for SETTLE cycles
          w_mismatch = (dut_f != EXP_TABLE[r_vec]);
          if (w_mismatch) begin
            w_err_nxt = r_err + (N_IN+1)'(1);
            if (!r_fail_valid) begin
              w_fail_valid_nxt = 1'b1;
              w_first_fail_nxt = r_vec;
            end
          end
          if ((r_vec == VEC_LAST) || (w_mismatch && r_stop)) begin
            w_state_nxt = S_DONE;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
            w_pass_nxt  = (w_err_nxt == '0);
          end else begin
            w_vec_nxt = r_vec + N_IN'(1);
            w_cnt_nxt = '0;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_vec        <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_err        <= '0;
      r_fail_valid <= 1'b0;
      r_first_fail <= '0;
      r_cnt        <= '0;
      r_stop       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_vec        <= w_vec_nxt;
      r_busy       <= w_busy_nxt;
      r_done       <= w_done_nxt;
      r_pass       <= w_pass_nxt;
      r_err        <= w_err_nxt;
      r_fail_valid <= w_fail_valid_nxt;
      r_first_fail <= w_first_fail_nxt;
      r_cnt        <= w_cnt_nxt;
      r_stop       <= w_stop_nxt;
    end
  end

  assign vec        = r_vec;
  assign busy       = r_busy;
  assign done       = r_done;
  assign pass       = r_pass;
  assign err_count  = r_err;
  assign fail_valid = r_fail_valid;
  assign first_fail = r_first_fail;

endmodule
